// File: rtl/alu_exec_ctrl.sv
// rtl/alu_exec_ctrl.sv - execute-stage sequencer around the 32-bit ALU with writeback handshake
// Optional ALU_EXEC_OVERLAP_EN lets a new instruction be accepted on the same edge as the writeback handshake.
module alu_exec_ctrl #(
  parameter int MUL_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_opcode,
  input  logic [3:0]  in_cond,
  input  logic        in_s,
  input  logic [2:0]  in_sr_cont,
  input  logic [4:0]  in_sr_bit,
  input  logic [15:0] in_imm,
  input  logic [3:0]  in_rd,
  input  logic [31:0] in_op1,
  input  logic [31:0] in_op2,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [3:0]  alu_opcode,
  output logic [3:0]  alu_cond,
  output logic        alu_s,
  output logic [2:0]  alu_sr_cont,
  output logic [4:0]  alu_sr_bit,
  output logic [15:0] alu_imm,
  input  logic [31:0] alu_out,
  input  logic [3:0]  alu_flags,
  input  logic        alu_cond_met,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic        wb_we,
  output logic [3:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [3:0]  flags_q
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL_WAIT, S_WB} state_t;

  localparam bit         MUL_MULTI = (MUL_CYCLES > 1);
  localparam logic [3:0] MUL_LOAD  = 4'(MUL_CYCLES - 2);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [3:0]  r_rd;
  logic        w_accept;
  logic        w_wb_hs;
  logic        w_is_mul;
  logic        w_wr_op;
  logic        w_flag_op;
  logic        w_capture;

`ifdef ALU_EXEC_OVERLAP_EN
  assign in_ready = ~rst & ((r_state == S_IDLE) | ((r_state == S_WB) & wb_ready));
`else
  assign in_ready = ~rst & (r_state == S_IDLE);
`endif

  assign wb_valid  = (r_state == S_WB);
  assign w_accept  = in_valid & in_ready;
  assign w_wb_hs   = wb_valid & wb_ready;
  assign w_is_mul  = (alu_opcode == 4'b0010);
  // Opcodes 0000..0111 and MOVI write a register; CMP, STR and undefined ones do not.
  assign w_wr_op   = ~alu_opcode[3] | (alu_opcode == 4'b1101);
  assign w_flag_op = alu_s | (alu_opcode == 4'b1011);
  assign w_capture = ((r_state == S_EXEC) & ~(w_is_mul & MUL_MULTI)) |
                     ((r_state == S_MUL_WAIT) & (r_cnt == 4'd0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_rd        <= 4'd0;
      alu_in1     <= 32'd0;
      alu_in2     <= 32'd0;
      alu_opcode  <= 4'd0;
      alu_cond    <= 4'd0;
      alu_s       <= 1'b0;
      alu_sr_cont <= 3'd0;
      alu_sr_bit  <= 5'd0;
      alu_imm     <= 16'd0;
      wb_we       <= 1'b0;
      wb_rd       <= 4'd0;
      wb_data     <= 32'd0;
      flags_q     <= 4'd0;
    end else begin
      if (w_accept) begin
        alu_in1     <= in_op1;
        alu_in2     <= in_op2;
        alu_opcode  <= in_opcode;
        alu_cond    <= in_cond;
        alu_s       <= in_s;
        alu_sr_cont <= in_sr_cont;
        alu_sr_bit  <= in_sr_bit;
        alu_imm     <= in_imm;
        r_rd        <= in_rd;
      end

      // A failed condition still yields a beat, but with zero data and no write.
      if (w_capture) begin
        wb_data <= alu_cond_met ? alu_out : 32'd0;
        wb_rd   <= r_rd;
        wb_we   <= alu_cond_met & w_wr_op;
        if (alu_cond_met & w_flag_op)
          flags_q <= alu_flags;
      end

      case (r_state)
        S_IDLE: begin
          if (w_accept)
            r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (w_is_mul & MUL_MULTI) begin
            r_cnt   <= MUL_LOAD;
            r_state <= S_MUL_WAIT;
          end else begin
            r_state <= S_WB;
          end
        end
        S_MUL_WAIT: begin
          if (r_cnt == 4'd0)
            r_state <= S_WB;
          else
            r_cnt <= r_cnt - 4'd1;
        end
        S_WB: begin
          if (w_wb_hs)
            r_state <= w_accept ? S_EXEC : S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb/tb_alu_exec_ctrl.sv - directed-vector bench for alu_exec_ctrl with a small behavioural ALU
module tb_alu_exec_ctrl;

  localparam int MUL_CYCLES = 3;
`ifdef ALU_EXEC_OVERLAP_EN
  localparam int BEAT_GAP = 2;
`else
  localparam int BEAT_GAP = 3;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_opcode = '0;
  logic [3:0]  in_cond = '0;
  logic        in_s = 1'b0;
  logic [2:0]  in_sr_cont = '0;
  logic [4:0]  in_sr_bit = '0;
  logic [15:0] in_imm = '0;
  logic [3:0]  in_rd = '0;
  logic [31:0] in_op1 = '0;
  logic [31:0] in_op2 = '0;
  logic [31:0] alu_in1, alu_in2;
  logic [3:0]  alu_opcode, alu_cond;
  logic        alu_s;
  logic [2:0]  alu_sr_cont;
  logic [4:0]  alu_sr_bit;
  logic [15:0] alu_imm;
  logic [31:0] alu_out;
  logic [3:0]  alu_flags;
  logic        alu_cond_met;
  logic        wb_valid;
  logic        wb_ready = 1'b1;
  logic        wb_we;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic [3:0]  flags_q;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  alu_exec_ctrl #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_cond(in_cond), .in_s(in_s),
    .in_sr_cont(in_sr_cont), .in_sr_bit(in_sr_bit), .in_imm(in_imm),
    .in_rd(in_rd), .in_op1(in_op1), .in_op2(in_op2),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_opcode(alu_opcode),
    .alu_cond(alu_cond), .alu_s(alu_s), .alu_sr_cont(alu_sr_cont),
    .alu_sr_bit(alu_sr_bit), .alu_imm(alu_imm),
    .alu_out(alu_out), .alu_flags(alu_flags), .alu_cond_met(alu_cond_met),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .flags_q(flags_q)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: ADD=0000, MUL=0010, CMP=1011, others pass operand 2; flags {N,Z,C,V}
  logic [32:0] m_wide;
  logic        m_c, m_v;
  always_comb begin
    m_wide  = 33'd0;
    m_c     = 1'b0;
    m_v     = 1'b0;
    alu_out = alu_in2;
    case (alu_opcode)
      4'b0000: begin
        m_wide  = {1'b0, alu_in1} + {1'b0, alu_in2};
        alu_out = m_wide[31:0];
        m_c     = m_wide[32];
        m_v     = (alu_in1[31] == alu_in2[31]) && (m_wide[31] != alu_in1[31]);
      end
      4'b0010: alu_out = alu_in1 * alu_in2;
      4'b1011: begin
        m_wide  = {1'b0, alu_in1} + {1'b0, ~alu_in2} + 33'd1;
        alu_out = m_wide[31:0];
        m_c     = m_wide[32];
        m_v     = (alu_in1[31] != alu_in2[31]) && (m_wide[31] != alu_in1[31]);
      end
      default: alu_out = alu_in2;
    endcase
    alu_flags = {alu_out[31], (alu_out == 32'd0), m_c, m_v};
    case (alu_cond)
      4'b0001: alu_cond_met = flags_q[2];
      4'b0010: alu_cond_met = !flags_q[2] && (flags_q[3] == flags_q[0]);
      default: alu_cond_met = 1'b1;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_instr(input logic [3:0] op, input logic [3:0] cond, input logic s,
                           input logic [31:0] a, input logic [31:0] b, input logic [3:0] rd);
    in_opcode = op; in_cond = cond; in_s = s; in_op1 = a; in_op2 = b; in_rd = rd;
  endtask

  // Issues one instruction; returns edges from accept to first wb_valid sample (-1 on timeout).
  task automatic do_instr(input logic [3:0] op, input logic [3:0] cond, input logic s,
                          input logic [31:0] a, input logic [31:0] b, input logic [3:0] rd,
                          output int lat);
    int t0;
    int n;
    @(negedge clk);
    set_instr(op, cond, s, a, b, rd);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      in_valid = 1'b0;
      lat = -1;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    t0 = cyc;
    n = 0;
    while (!wb_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    lat = wb_valid ? (cyc - t0 + 1) : -1;
  endtask

  int lat;
  int nb;
  int t_acc;
  int k;
  logic acc;
  int beat_t [4];
  logic [31:0] beat_d [4];

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_wb_valid", 32'(wb_valid), 32'd0);
    check_eq("rst_flags", 32'(flags_q), 32'd0);
    check_eq("rst_alu_in1", alu_in1, 32'd0);
    check_eq("rst_wb_data", wb_data, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);

    // ADD overflow, s=1
    do_instr(4'b0000, 4'b0000, 1'b1, 32'h7FFF_FFFF, 32'd1, 4'd3, lat);
    check_eq("add_lat", 32'(lat), 32'd2);
    check_eq("add_data", wb_data, 32'h8000_0000);
    check_eq("add_we", 32'(wb_we), 32'd1);
    check_eq("add_rd", 32'(wb_rd), 32'd3);
    check_eq("add_flags", 32'(flags_q), 32'b1001);
    check_eq("wb_in_ready", 32'(in_ready), 32'(BEAT_GAP == 2));

    // MUL: first wb_valid exactly MUL_CYCLES+1 after accept
    do_instr(4'b0010, 4'b0000, 1'b0, 32'd6, 32'd7, 4'd5, lat);
    check_eq("mul_lat", 32'(lat), 32'd4);
    check_eq("mul_data", wb_data, 32'd42);
    check_eq("mul_we", 32'(wb_we), 32'd1);
    check_eq("mul_flags_hold", 32'(flags_q), 32'b1001);

    // CMP sets flags without a write
    do_instr(4'b1011, 4'b0000, 1'b0, 32'd5, 32'd5, 4'd1, lat);
    check_eq("cmp_lat", 32'(lat), 32'd2);
    check_eq("cmp_we", 32'(wb_we), 32'd0);
    check_eq("cmp_flags", 32'(flags_q), 32'b0110);

    // ADD EQ after CMP equal
    do_instr(4'b0000, 4'b0001, 1'b0, 32'd3, 32'd3, 4'd2, lat);
    check_eq("addeq_we", 32'(wb_we), 32'd1);
    check_eq("addeq_data", wb_data, 32'd6);
    check_eq("addeq_rd", 32'(wb_rd), 32'd2);

    // ADD GT with Z set: condition fails
    do_instr(4'b0000, 4'b0010, 1'b1, 32'd1, 32'd2, 4'd4, lat);
    check_eq("addgt_valid", 32'(wb_valid), 32'd1);
    check_eq("addgt_we", 32'(wb_we), 32'd0);
    check_eq("addgt_data", wb_data, 32'd0);
    check_eq("addgt_flags", 32'(flags_q), 32'b0110);

    // Writeback stall
    @(negedge clk);
    wb_ready = 1'b0;
    do_instr(4'b0000, 4'b0000, 1'b0, 32'd10, 32'd20, 4'd7, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("stall_valid", 32'(wb_valid), 32'd1);
      check_eq("stall_data", wb_data, 32'd30);
      check_eq("stall_rd", 32'(wb_rd), 32'd7);
      check_eq("stall_in_ready", 32'(in_ready), 32'd0);
    end
    wb_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("stall_release_valid", 32'(wb_valid), 32'd0);

    // Reset during MUL_WAIT
    @(negedge clk);
    set_instr(4'b0010, 4'b0000, 1'b1, 32'd2, 32'd3, 4'd9);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("midrst_valid", 32'(wb_valid), 32'd0);
    check_eq("midrst_flags", 32'(flags_q), 32'd0);
    check_eq("midrst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("midrst_release_in_ready", 32'(in_ready), 32'd1);
    check_eq("midrst_release_valid", 32'(wb_valid), 32'd0);

    // Back-to-back ADDs with wb_ready held high
    @(negedge clk);
    k = 0;
    nb = 0;
    t_acc = 0;
    set_instr(4'b0000, 4'b0000, 1'b0, 32'd1, 32'd1, 4'd1);
    in_valid = 1'b1;
    for (int i = 0; i < 40 && nb < 4; i++) begin
      if (i > 0) @(negedge clk);
      if (wb_valid) begin
        beat_t[nb] = cyc;
        beat_d[nb] = wb_data;
        nb++;
      end
      acc = in_valid & in_ready;
      if (acc && k == 0) t_acc = cyc;
      @(posedge clk); #1;
      if (acc) begin
        k++;
        if (k < 4) set_instr(4'b0000, 4'b0000, 1'b0, 32'(k + 1), 32'(k + 1), 4'(k + 1));
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check_eq("b2b_beats", 32'(nb), 32'd4);
    if (nb == 4) begin
      check_eq("b2b_first", 32'(beat_t[0] - t_acc), 32'd2);
      for (int j = 1; j < 4; j++) begin
        check_eq("b2b_gap", 32'(beat_t[j] - beat_t[j-1]), 32'(BEAT_GAP));
      end
      for (int j = 0; j < 4; j++) begin
        check_eq("b2b_data", beat_d[j], 32'(2 * j + 2));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
